ram2_arbiter: RTL and testbench
===============================

Name: ram2_arbiter

Overview:
- Shares the single RAM2 SRAM between the instruction-fetch requester (pc) and the data requester (MEM stage), so code and data can live in the same 64K-word memory.
- Sequences SRAM read and write timing and owns the tristate data bus.
- Raises a stall toward the fetch side while the data side holds the SRAM.
- Sits between pc/mem logic and the ram2_* board pins.

Parameters:
ADDR_W, 16, SRAM address width
DATA_W, 16, SRAM data width
READ_WAIT, 1, cycles in RD with oe low (min 1)
WRITE_WAIT, 1, cycles in WR_PULSE with we low (min 1)

Ports:
rai_clk  in  1  system clock (sole clock)
rai_rst  in  1  reset; asynchronous, active-low
rai_if_req  in  1  fetch read request, level, held until ack
rai_if_addr  in  ADDR_W  fetch address
rao_if_data  out  DATA_W  fetched word, valid while rao_if_ack=1
rao_if_ack  out  1  one-cycle completion pulse
rao_if_stall  out  1  rai_if_req & ~rao_if_ack (combinational)
rai_mem_req  in  1  data request, level, held until ack
rai_mem_we  in  1  1=write, 0=read; sampled at grant
rai_mem_addr  in  ADDR_W  data address
rai_mem_wdata  in  DATA_W  write data
rao_mem_rdata  out  DATA_W  read word, valid while rao_mem_ack=1
rao_mem_ack  out  1  one-cycle completion pulse
rao_ram2_en  out  1  SRAM chip enable, active-low
rao_ram2_oe  out  1  SRAM output enable, active-low
rao_ram2_we  out  1  SRAM write enable, active-low
rao_ram2_addr  out  ADDR_W  SRAM address
rao_ram2_data  inout  DATA_W  SRAM data bus

Behaviour:
- Reset (rai_rst=0, async):
  - state=IDLE; en=oe=we=1; addr=0; data bus Z; both acks=0; rdata/if_data=0; owner=none.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. All SRAM control outputs are registered.
- IDLE:
  - If rai_mem_req: grant mem, latch addr/we/wdata. Go to RD if we=0, else WR_SETUP.
  - Else if rai_if_req: grant if, latch addr, go to RD.
  - Fixed priority, mem over if. On simultaneous requests, mem is served first and if is served on the next IDLE.
- RD:
  - en=0, oe=0, we=1, bus Z, addr=latched; held READ_WAIT cycles.
  - Data is sampled at the final RD clock edge into the owner's data register. Then go to DONE.
- WR_SETUP (1 cycle): en=0, oe=1, we=1, bus driven with wdata.
- WR_PULSE: we=0 for WRITE_WAIT cycles, bus driven.
- WR_HOLD (1 cycle): we=1, bus still driven. Then go to DONE.
- DONE (1 cycle):
  - en=1, oe=1, bus Z; owner's ack=1; then IDLE.
  - A requester samples ack at the clock edge and must drop or renew its req by the following cycle.
  - IDLE is only entered after DONE, so a stale req cannot be double-served.
- Latency from the IDLE cycle that sees req to ack: READ_WAIT+1 cycles for reads (2 at default), WRITE_WAIT+3 for writes (4 at default).
- Bus safety invariants:
  - Bus is driven only in WR_* states.
  - oe=0 never coincides with a driven bus.
  - we and oe are never both 0.
- Requester inputs that change after grant are ignored until the next grant.
- A request that arrives while busy waits. There is no queue beyond the level request itself.
- Back-to-back mem requests starve if; the mem side issues at most one request per instruction, so this is accepted.
- Reset mid-transaction aborts immediately: we returns to 1 asynchronously and the bus goes Z. A partial write is permitted.
- rao_if_stall is high from the first cycle of rai_if_req until the ack cycle, inclusive of time the mem side owns the SRAM.

Decomposition:
- Shared include ram2_arb_defs: state encodings (3-bit), owner encoding (NONE/IF/MEM), default wait constants.
- Single flat module. Tristate handled with one continuous assignment from a drive-enable register. No sub-module.

Test Plan:
- Reset: hold rai_rst=0 mid-WR_PULSE → en/oe/we=1, data bus Z, acks 0 immediately (async, no clock edge needed).
- Fetch read: SRAM model holds 0x1234 @0x0040; if_req, addr=0x0040 → oe=0 for 1 cycle; if_ack pulse 2 cycles after grant with if_data=0x1234; stall high until that cycle.
- Data write then read: mem write 0xBEEF @0x8001 → we low exactly WRITE_WAIT cycles, bus=0xBEEF from WR_SETUP through WR_HOLD, ack at cycle 4. Following mem read → rdata=0xBEEF.
- Simultaneous: if_req @0x0010 and mem_req read @0x0020 in the same cycle → SRAM addr 0x0020 first, mem_ack, then 0x0010, if_ack. if_stall stays high throughout.
- Held req: requester keeps req high one cycle after ack → exactly one additional transaction, no duplicate ack within DONE→IDLE.
- Protocol checker across random traffic (READ_WAIT=2, WRITE_WAIT=3): assert no oe=0 while the bus is driven, we/oe never both 0, and every req gets exactly one ack.

Source files
------------

// File: rtl/ram2_arbiter_pkg.sv
// ram2_arbiter_pkg: state and owner encodings plus default wait constants for the RAM2 arbiter.
package ram2_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;
    localparam int DEF_READ_WAIT  = 1;
    localparam int DEF_WRITE_WAIT = 1;
    localparam int CNT_W          = 8;
endpackage

// File: rtl/ram2_arbiter_if.sv
// ram2_arbiter_if: fetch and data requester handshakes toward the RAM2 arbiter.
interface ram2_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              rai_if_req;
    logic [ADDR_W-1:0] rai_if_addr;
    logic [DATA_W-1:0] rao_if_data;
    logic              rao_if_ack;
    logic              rao_if_stall;
    logic              rai_mem_req;
    logic              rai_mem_we;
    logic [ADDR_W-1:0] rai_mem_addr;
    logic [DATA_W-1:0] rai_mem_wdata;
    logic [DATA_W-1:0] rao_mem_rdata;
    logic              rao_mem_ack;
    modport slave (
        input  rai_if_req, rai_if_addr, rai_mem_req, rai_mem_we, rai_mem_addr, rai_mem_wdata,
        output rao_if_data, rao_if_ack, rao_if_stall, rao_mem_rdata, rao_mem_ack
    );
    modport master (
        output rai_if_req, rai_if_addr, rai_mem_req, rai_mem_we, rai_mem_addr, rai_mem_wdata,
        input  rao_if_data, rao_if_ack, rao_if_stall, rao_mem_rdata, rao_mem_ack
    );
endinterface

// File: rtl/ram2_arbiter.sv
// ram2_arbiter: shares the RAM2 SRAM between fetch and data requesters (data first),
// sequencing registered read/write strobes and owning the tristate data bus.
module ram2_arbiter
    import ram2_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int READ_WAIT  = DEF_READ_WAIT,
    parameter int WRITE_WAIT = DEF_WRITE_WAIT
) (
    input  logic              rai_clk,
    input  logic              rai_rst,
    ram2_arbiter_if.slave     bus,
    output logic              rao_ram2_en,
    output logic              rao_ram2_oe,
    output logic              rao_ram2_we,
    output logic [ADDR_W-1:0] rao_ram2_addr,
    inout  wire  [DATA_W-1:0] rao_ram2_data
);
    state_t            r_state, w_state_nx;
    owner_t            r_owner, w_owner_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_drive;
    logic              w_grant, w_sample;

    assign w_grant  = (r_state == IDLE) && (bus.rai_mem_req || bus.rai_if_req);
    assign w_sample = (r_state == RD) && (r_cnt == '0);

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_cnt_nx   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.rai_mem_req) begin
                    w_owner_nx = OWN_MEM;
                    w_state_nx = bus.rai_mem_we ? WR_SETUP : RD;
                    w_cnt_nx   = bus.rai_mem_we ? CNT_W'(WRITE_WAIT - 1) : CNT_W'(READ_WAIT - 1);
                end else if (bus.rai_if_req) begin
                    w_owner_nx = OWN_IF;
                    w_state_nx = RD;
                    w_cnt_nx   = CNT_W'(READ_WAIT - 1);
                end
            end
            RD, WR_PULSE: begin
                w_cnt_nx = r_cnt - CNT_W'(1);
                if (r_cnt == '0) w_state_nx = (r_state == RD) ? DONE : WR_HOLD;
            end
            WR_SETUP: w_state_nx = WR_PULSE;
            WR_HOLD:  w_state_nx = DONE;
            default: begin
                w_state_nx = IDLE;
                w_owner_nx = OWN_NONE;
            end
        endcase
    end

    // Strobes are decoded from the next state so every SRAM pin comes straight off a flop.
    always_ff @(posedge rai_clk or negedge rai_rst) begin
        if (!rai_rst) begin
            r_state           <= IDLE;
            r_owner           <= OWN_NONE;
            r_cnt             <= '0;
            r_wdata           <= '0;
            r_drive           <= 1'b0;
            rao_ram2_en       <= 1'b1;
            rao_ram2_oe       <= 1'b1;
            rao_ram2_we       <= 1'b1;
            rao_ram2_addr     <= '0;
            bus.rao_if_ack    <= 1'b0;
            bus.rao_mem_ack   <= 1'b0;
            bus.rao_if_data   <= '0;
            bus.rao_mem_rdata <= '0;
        end else begin
            r_state         <= w_state_nx;
            r_owner         <= w_owner_nx;
            r_cnt           <= w_cnt_nx;
            r_drive         <= w_state_nx inside {WR_SETUP, WR_PULSE, WR_HOLD};
            rao_ram2_en     <= !(w_state_nx inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
            rao_ram2_oe     <= w_state_nx != RD;
            rao_ram2_we     <= w_state_nx != WR_PULSE;
            bus.rao_if_ack  <= (w_state_nx == DONE) && (r_owner == OWN_IF);
            bus.rao_mem_ack <= (w_state_nx == DONE) && (r_owner == OWN_MEM);
            if (w_grant) begin
                rao_ram2_addr <= bus.rai_mem_req ? bus.rai_mem_addr : bus.rai_if_addr;
                r_wdata       <= bus.rai_mem_wdata;
            end
            if (w_sample && r_owner == OWN_IF) bus.rao_if_data <= rao_ram2_data;
            if (w_sample && r_owner == OWN_MEM) bus.rao_mem_rdata <= rao_ram2_data;
        end
    end

    assign rao_ram2_data    = r_drive ? r_wdata : 'z;
    assign bus.rao_if_stall = bus.rai_if_req & ~bus.rao_if_ack;
endmodule

// File: tb/tb_ram2_arbiter.sv
// tb_ram2_arbiter: two arbiter configs (default waits; READ_WAIT=2/WRITE_WAIT=3) each checked every
// cycle against a transaction-phase model; directed cases drive config 0, random traffic config 1.
module tb_ram2_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  if_req, mem_req, mem_we;
    logic [15:0] if_addr [2];
    logic [15:0] mem_addr [2];
    logic [15:0] mem_wdata [2];
    int checks = 0;
    int failures = 0;
    int raised_if = 0, raised_mem = 0, acked_if = 0, acked_mem = 0;
    logic a_if, a_mem;

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return a ^ 16'h1274;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int RW = (g == 0) ? 1 : 2;
        localparam int WW = (g == 0) ? 1 : 3;
        ram2_arbiter_if #(.ADDR_W(16), .DATA_W(16)) u_if ();
        wire  [15:0] ram2_data;
        logic        en, oe, we;
        logic [15:0] addr;
        logic [15:0] sram [0:65535];
        logic [15:0] exp_mem [0:65535];
        int          cyc = 0, st = 0, fin = 0, ph = 0;
        logic        busy = 1'b0, m_mem = 1'b0, m_wr = 1'b0;
        logic [15:0] m_addr = '0, m_wdata = '0;
        logic        in_rd, in_wr, pulse, done;

        assign u_if.rai_if_req    = if_req[g];
        assign u_if.rai_if_addr   = if_addr[g];
        assign u_if.rai_mem_req   = mem_req[g];
        assign u_if.rai_mem_we    = mem_we[g];
        assign u_if.rai_mem_addr  = mem_addr[g];
        assign u_if.rai_mem_wdata = mem_wdata[g];

        ram2_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_WAIT(RW), .WRITE_WAIT(WW)) u_dut (
            .rai_clk      (clk),
            .rai_rst      (rst_n),
            .bus          (u_if),
            .rao_ram2_en  (en),
            .rao_ram2_oe  (oe),
            .rao_ram2_we  (we),
            .rao_ram2_addr(addr),
            .rao_ram2_data(ram2_data)
        );

        assign ram2_data = (!en && !oe) ? sram[addr] : 16'hzzzz;

        initial begin
            for (int i = 0; i < 65536; i++) begin
                sram[i]    = init_word(16'(i));
                exp_mem[i] = init_word(16'(i));
            end
        end

        always @(negedge clk) if (!en && !we) sram[addr] = ram2_data;

        // Transaction model: a grant happens on any free cycle with a request; outputs follow
        // from the phase offset since that grant.
        always @(negedge clk) begin
            if (!rst_n) begin
                busy = 1'b0;
            end else begin
                cyc++;
                if (!busy && (mem_req[g] || if_req[g])) begin
                    busy    = 1'b1;
                    st      = cyc;
                    m_mem   = mem_req[g];
                    m_wr    = mem_req[g] & mem_we[g];
                    m_addr  = mem_req[g] ? mem_addr[g] : if_addr[g];
                    m_wdata = mem_wdata[g];
                    fin     = st + (m_wr ? WW + 3 : RW + 1);
                end
                ph    = cyc - st;
                in_rd = busy && !m_wr && ph >= 1 && ph <= RW;
                in_wr = busy && m_wr && ph >= 1 && ph <= WW + 2;
                pulse = in_wr && ph >= 2 && ph <= WW + 1;
                done  = busy && cyc == fin;
                chk($sformatf("c%0d_en", g), en, !(in_rd || in_wr));
                chk($sformatf("c%0d_oe", g), oe, !in_rd);
                chk($sformatf("c%0d_we", g), we, !pulse);
                chk($sformatf("c%0d_we_oe_both_low", g), !we && !oe, 1'b0);
                chk($sformatf("c%0d_if_ack", g), u_if.rao_if_ack, done && !m_mem);
                chk($sformatf("c%0d_mem_ack", g), u_if.rao_mem_ack, done && m_mem);
                chk($sformatf("c%0d_stall", g), u_if.rao_if_stall, if_req[g] && !(done && !m_mem));
                if (in_rd || in_wr) chk($sformatf("c%0d_addr", g), addr, m_addr);
                if (in_wr) chk($sformatf("c%0d_bus", g), ram2_data, m_wdata);
                if (done && !m_wr && m_mem) chk($sformatf("c%0d_mem_rdata", g), u_if.rao_mem_rdata, exp_mem[m_addr]);
                if (done && !m_wr && !m_mem) chk($sformatf("c%0d_if_data", g), u_if.rao_if_data, exp_mem[m_addr]);
                if (done && m_wr) exp_mem[m_addr] = m_wdata;
                if (done) busy = 1'b0;
            end
        end
    end

    task automatic rand_step(input logic allow_new);
        @(negedge clk);
        #1;
        a_if  = cfg[1].u_if.rao_if_ack;
        a_mem = cfg[1].u_if.rao_mem_ack;
        acked_if  += int'(a_if);
        acked_mem += int'(a_mem);
        tick();
        if (a_if) if_req[1] = 1'b0;
        else if (allow_new && !if_req[1] && $urandom_range(0, 2) == 0) begin
            if_req[1]  = 1'b1;
            if_addr[1] = 16'h4000 | 16'($urandom_range(0, 15));
            raised_if++;
        end
        if (a_mem) mem_req[1] = 1'b0;
        else if (allow_new && !mem_req[1] && $urandom_range(0, 2) == 0) begin
            mem_req[1]  = 1'b1;
            mem_we[1]   = 1'($urandom_range(0, 1));
            mem_addr[1] = 16'h4000 | 16'($urandom_range(0, 15));
            raised_mem++;
        end
        mem_wdata[1] = 16'($urandom);
    endtask

    initial begin
        rst_n   = 1'b0;
        if_req  = '0;
        mem_req = '0;
        mem_we  = '0;
        for (int k = 0; k < 2; k++) begin
            if_addr[k]   = '0;
            mem_addr[k]  = '0;
            mem_wdata[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", cfg[0].en, 1'b1);
        chk("rst_oe", cfg[0].oe, 1'b1);
        chk("rst_we", cfg[0].we, 1'b1);
        chk("rst_addr", cfg[0].addr, 16'h0000);
        chk("rst_if_ack", cfg[0].u_if.rao_if_ack, 1'b0);
        chk("rst_mem_ack", cfg[0].u_if.rao_mem_ack, 1'b0);
        chk("rst_if_data", cfg[0].u_if.rao_if_data, 16'h0000);
        chk("rst_mem_rdata", cfg[0].u_if.rao_mem_rdata, 16'h0000);
        rst_n = 1'b1;
        tick();
        // fetch read of 0x0040 (preloaded 0x1234)
        if_req[0] = 1'b1; if_addr[0] = 16'h0040;
        tick();
        chk("fetch_oe_c1", cfg[0].oe, 1'b0);
        chk("fetch_addr_c1", cfg[0].addr, 16'h0040);
        chk("fetch_stall_c1", cfg[0].u_if.rao_if_stall, 1'b1);
        tick();
        chk("fetch_ack_c2", cfg[0].u_if.rao_if_ack, 1'b1);
        chk("fetch_data_c2", cfg[0].u_if.rao_if_data, 16'h1234);
        chk("fetch_stall_c2", cfg[0].u_if.rao_if_stall, 1'b0);
        tick();
        if_req[0] = 1'b0;
        // data write 0xBEEF @0x8001
        mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_addr[0] = 16'h8001; mem_wdata[0] = 16'hBEEF;
        tick();
        chk("wr_setup_we", cfg[0].we, 1'b1);
        chk("wr_setup_en", cfg[0].en, 1'b0);
        chk("wr_setup_bus", cfg[0].ram2_data, 16'hBEEF);
        tick();
        chk("wr_pulse_we", cfg[0].we, 1'b0);
        chk("wr_pulse_bus", cfg[0].ram2_data, 16'hBEEF);
        tick();
        chk("wr_hold_we", cfg[0].we, 1'b1);
        chk("wr_hold_bus", cfg[0].ram2_data, 16'hBEEF);
        chk("wr_hold_ack", cfg[0].u_if.rao_mem_ack, 1'b0);
        tick();
        chk("wr_done_ack", cfg[0].u_if.rao_mem_ack, 1'b1);
        chk("wr_done_en", cfg[0].en, 1'b1);
        tick();
        mem_req[0] = 1'b0;
        chk("wr_after_ack", cfg[0].u_if.rao_mem_ack, 1'b0);
        // read back
        mem_req[0] = 1'b1; mem_we[0] = 1'b0;
        tick();
        chk("rd_oe_c1", cfg[0].oe, 1'b0);
        tick();
        chk("rd_ack_c2", cfg[0].u_if.rao_mem_ack, 1'b1);
        chk("rd_data_c2", cfg[0].u_if.rao_mem_rdata, 16'hBEEF);
        tick();
        mem_req[0] = 1'b0;
        // simultaneous: mem read 0x0020 wins over fetch 0x0010
        if_req[0] = 1'b1; if_addr[0] = 16'h0010;
        mem_req[0] = 1'b1; mem_addr[0] = 16'h0020;
        tick();
        chk("sim_addr_mem", cfg[0].addr, 16'h0020);
        chk("sim_stall_c1", cfg[0].u_if.rao_if_stall, 1'b1);
        tick();
        chk("sim_mem_ack", cfg[0].u_if.rao_mem_ack, 1'b1);
        chk("sim_if_ack_c2", cfg[0].u_if.rao_if_ack, 1'b0);
        chk("sim_mem_data", cfg[0].u_if.rao_mem_rdata, 16'h1254);
        chk("sim_stall_c2", cfg[0].u_if.rao_if_stall, 1'b1);
        tick();
        mem_req[0] = 1'b0;
        chk("sim_stall_c3", cfg[0].u_if.rao_if_stall, 1'b1);
        tick();
        chk("sim_addr_if", cfg[0].addr, 16'h0010);
        chk("sim_oe_c4", cfg[0].oe, 1'b0);
        tick();
        chk("sim_if_ack", cfg[0].u_if.rao_if_ack, 1'b1);
        chk("sim_if_data", cfg[0].u_if.rao_if_data, 16'h1264);
        chk("sim_stall_c5", cfg[0].u_if.rao_if_stall, 1'b0);
        // fetch req stays high one cycle past its ack: exactly one more transaction
        tick();
        chk("held_no_dup_ack", cfg[0].u_if.rao_if_ack, 1'b0);
        chk("held_stall", cfg[0].u_if.rao_if_stall, 1'b1);
        tick();
        chk("held_rd_oe", cfg[0].oe, 1'b0);
        tick();
        chk("held_second_ack", cfg[0].u_if.rao_if_ack, 1'b1);
        tick();
        if_req[0] = 1'b0;
        chk("held_ack_gone", cfg[0].u_if.rao_if_ack, 1'b0);
        tick();
        tick();
        chk("held_idle_en", cfg[0].en, 1'b1);
        chk("held_idle_ack", cfg[0].u_if.rao_if_ack, 1'b0);
        // reset in the middle of WR_PULSE
        mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_addr[0] = 16'h3000; mem_wdata[0] = 16'h5555;
        tick();
        tick();
        chk("abort_pre_we", cfg[0].we, 1'b0);
        rst_n = 1'b0;
        mem_req[0] = 1'b0;
        #1;
        chk("abort_we", cfg[0].we, 1'b1);
        chk("abort_en", cfg[0].en, 1'b1);
        chk("abort_oe", cfg[0].oe, 1'b1);
        chk("abort_mem_ack", cfg[0].u_if.rao_mem_ack, 1'b0);
        chk("abort_if_ack", cfg[0].u_if.rao_if_ack, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        // random protocol traffic on the READ_WAIT=2 / WRITE_WAIT=3 config
        for (int c = 0; c < 600; c++) rand_step(1'b1);
        for (int c = 0; c < 40 && (if_req[1] || mem_req[1]); c++) rand_step(1'b0);
        chk("drain_if_idle", if_req[1], 1'b0);
        chk("drain_mem_idle", mem_req[1], 1'b0);
        chk("rand_if_one_ack_each", acked_if, raised_if);
        chk("rand_mem_one_ack_each", acked_mem, raised_mem);
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
